// File: rtl/awgn_pkg.sv
// Shared definitions for the AWGN source chain: taus88 masks, shift amounts,
// seed floors, the per-channel generator state record and the URNG control states.
// Also provides the taus88 component recurrence and the seed sanitiser.
package awgn_pkg;

  localparam logic [31:0] TAUS_M1 = 32'hFFFFFFFE;
  localparam logic [31:0] TAUS_M2 = 32'hFFFFFFF8;
  localparam logic [31:0] TAUS_M3 = 32'hFFFFFFF0;

  // Shift triples per component: (feedback left, feedback right, masked left)
  localparam int TAUS_A1 = 13;
  localparam int TAUS_B1 = 19;
  localparam int TAUS_C1 = 12;
  localparam int TAUS_A2 = 2;
  localparam int TAUS_B2 = 25;
  localparam int TAUS_C2 = 4;
  localparam int TAUS_A3 = 3;
  localparam int TAUS_B3 = 11;
  localparam int TAUS_C3 = 17;

  // Minimum component values; anything below collapses the recurrence to zero
  localparam logic [31:0] TAUS_FLOOR1 = 32'd2;
  localparam logic [31:0] TAUS_FLOOR2 = 32'd8;
  localparam logic [31:0] TAUS_FLOOR3 = 32'd16;

  // Packed so that the 96-bit seed word {s3,s2,s1} maps onto it directly
  typedef struct packed {
    logic [31:0] s3;
    logic [31:0] s2;
    logic [31:0] s1;
  } taus_state_t;

  typedef enum logic {
    ST_UNSEEDED = 1'b0,
    ST_RUN      = 1'b1
  } urng_state_t;

  function automatic logic [31:0] taus_comp(input logic [31:0] s, input logic [31:0] m,
                                            input int a, input int b, input int c);
    return ((s & m) << c) ^ (((s << a) ^ s) >> b);
  endfunction

  function automatic taus_state_t taus_sanitize(input taus_state_t s);
    taus_state_t r;
    r = s;
    if (s.s1 < TAUS_FLOOR1) r.s1 = s.s1 | TAUS_FLOOR1;
    if (s.s2 < TAUS_FLOOR2) r.s2 = s.s2 | TAUS_FLOOR2;
    if (s.s3 < TAUS_FLOOR3) r.s3 = s.s3 | TAUS_FLOOR3;
    return r;
  endfunction

endpackage

// File: rtl/taus88_urng_mc_step.sv
// Combinational taus88 advance for one channel.
// Ports:
//   state_cur  in   96  current state {s3,s2,s1}
//   state_nxt  out  96  advanced state {s3',s2',s1'}
//   sample     out  32  s1'^s2'^s3'
module taus88_step
  import awgn_pkg::*;
(
  input  logic [95:0] state_cur,
  output logic [95:0] state_nxt,
  output logic [31:0] sample
);

  taus_state_t cur;
  taus_state_t nxt;

  always_comb begin
    cur    = taus_state_t'(state_cur);
    nxt.s1 = taus_comp(cur.s1, TAUS_M1, TAUS_A1, TAUS_B1, TAUS_C1);
    nxt.s2 = taus_comp(cur.s2, TAUS_M2, TAUS_A2, TAUS_B2, TAUS_C2);
    nxt.s3 = taus_comp(cur.s3, TAUS_M3, TAUS_A3, TAUS_B3, TAUS_C3);
  end

  assign state_nxt = nxt;
  assign sample    = nxt.s1 ^ nxt.s2 ^ nxt.s3;

endmodule

// File: rtl/taus88_urng_mc.sv
// Multi-channel taus88 uniform generator with seed load port and a registered
// valid/ready output. All channels advance together, one step per generated beat.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   enable                0 freezes generation and holds the output register
//   seed_valid/seed_ch/seed_data/seed_ready  seed load ({s3,s2,s1}); always ready
//   out_valid/out_ready/out_data             NUM_CH x 32-bit beats, channel k at [32k+31:32k]
//   running               high once every channel has been seeded
//   sample_cnt            delivered-beat counter, wraps
module taus88_urng_mc
  import awgn_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CH_W   = 1,
  parameter int CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  seed_valid,
  input  logic [CH_W-1:0]       seed_ch,
  input  logic [95:0]           seed_data,
  output logic                  seed_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*NUM_CH-1:0]  out_data,
  output logic                  running,
  output logic [CNT_W-1:0]      sample_cnt
);

  urng_state_t            fsm;
  logic                   seed_wr;
  logic                   adv;
  logic                   deliver;
  logic [NUM_CH-1:0]      seeded;
  logic [NUM_CH-1:0]      seed_sel;
  logic [96*NUM_CH-1:0]   st_all;
  logic [96*NUM_CH-1:0]   nxt_all;
  logic [32*NUM_CH-1:0]   smp_all;

  assign seed_ready = 1'b1;
  assign seed_wr    = seed_valid;
  assign running    = (fsm == ST_RUN);
  assign deliver    = out_valid && out_ready;
  // A seed write always pre-empts generation so the new seed is never stepped
  // in the cycle it lands.
  assign adv        = running && enable && (!out_valid || out_ready) && !seed_wr;

  // Out-of-range channel numbers match no bit and are silently dropped
  always_comb begin
    seed_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (seed_wr && (seed_ch == CH_W'(k))) seed_sel[k] = 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    taus88_step u_step (
      .state_cur (st_all[96*k +: 96]),
      .state_nxt (nxt_all[96*k +: 96]),
      .sample    (smp_all[32*k +: 32])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_all <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (seed_sel[k])
          st_all[96*k +: 96] <= taus_sanitize(taus_state_t'(seed_data));
        else if (adv)
          st_all[96*k +: 96] <= nxt_all[96*k +: 96];
      end
    end
  end

  // The flag written this cycle counts, so the last seed enters RUN immediately
  always_ff @(posedge clk) begin
    if (reset) begin
      seeded <= '0;
      fsm    <= ST_UNSEEDED;
    end else begin
      seeded <= seeded | seed_sel;
      if (fsm == ST_UNSEEDED && (&(seeded | seed_sel))) fsm <= ST_RUN;
    end
  end

  // Output register: a seed write invalidates any pending beat (it was drawn
  // from a state that no longer exists); a delivery without a new step empties it.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      out_valid <= 1'b1;
      out_data  <= smp_all;
    end else if (seed_wr || deliver) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)        sample_cnt <= '0;
    else if (deliver) sample_cnt <= sample_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_taus88_urng_mc.sv
// Bench for taus88_urng_mc: directed scenarios plus randomized traffic, with a
// transaction-level model that predicts every delivered beat from seeds alone.
module tb_taus88_urng_mc;

  localparam int NUM_CH = 2;
  localparam int CH_W   = 1;
  localparam int CNT_W  = 4;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  enable = 1'b0;
  logic                  seed_valid = 1'b0;
  logic [CH_W-1:0]       seed_ch = '0;
  logic [95:0]           seed_data = '0;
  logic                  seed_ready;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [32*NUM_CH-1:0]  out_data;
  logic                  running;
  logic [CNT_W-1:0]      sample_cnt;

  taus88_urng_mc #(.NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .seed_valid (seed_valid),
    .seed_ch    (seed_ch),
    .seed_data  (seed_data),
    .seed_ready (seed_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .running    (running),
    .sample_cnt (sample_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint unsigned pw2(input int n);
    longint unsigned p = 1;
    for (int i = 0; i < n; i++) p = p * 2;
    return p;
  endfunction

  // One component of the recurrence in modulo-2^32 arithmetic
  function automatic logic [31:0] ref_comp(input logic [31:0] s, input logic [31:0] m,
                                           input int a, input int b, input int c);
    longint unsigned W = 64'h1_0000_0000;
    longint unsigned x, y, t;
    x = longint'(s & m);
    y = longint'(s);
    x = (x * pw2(c)) % W;
    t = ((y * pw2(a)) % W) ^ y;
    t = t / pw2(b);
    return 32'(x ^ t);
  endfunction

  function automatic logic [31:0] fix(input logic [31:0] v, input logic [31:0] floor_v);
    return (v < floor_v) ? (v | floor_v) : v;
  endfunction

  logic [31:0] ms1 [NUM_CH];
  logic [31:0] ms2 [NUM_CH];
  logic [31:0] ms3 [NUM_CH];
  logic [CNT_W-1:0] mcnt;

  function automatic logic [31:0] n1(input logic [31:0] s); return ref_comp(s, 32'hFFFFFFFE, 13, 19, 12); endfunction
  function automatic logic [31:0] n2(input logic [31:0] s); return ref_comp(s, 32'hFFFFFFF8, 2, 25, 4);   endfunction
  function automatic logic [31:0] n3(input logic [31:0] s); return ref_comp(s, 32'hFFFFFFF0, 3, 11, 17);  endfunction

  function automatic logic [63:0] predict();
    logic [63:0] r;
    for (int k = 0; k < NUM_CH; k++)
      r[32*k +: 32] = n1(ms1[k]) ^ n2(ms2[k]) ^ n3(ms3[k]);
    return r;
  endfunction

  task automatic model_step();
    for (int k = 0; k < NUM_CH; k++) begin
      ms1[k] = n1(ms1[k]);
      ms2[k] = n2(ms2[k]);
      ms3[k] = n3(ms3[k]);
    end
  endtask

  // Observes each cycle's handshake/seed activity just before the edge that acts on it
  always @(negedge clk) begin
    if (reset) begin
      mcnt = '0;
      for (int k = 0; k < NUM_CH; k++) begin
        ms1[k] = '0; ms2[k] = '0; ms3[k] = '0;
      end
    end else begin
      check("cnt", 64'(sample_cnt), 64'(mcnt));
      if (out_valid && out_ready) begin
        check("beat", out_data, predict());
        model_step();
        mcnt = mcnt + 1'b1;
      end else if (seed_valid && out_valid) begin
        // undelivered beat discarded by the seed write: its step is still consumed
        model_step();
      end
      if (seed_valid && (int'(seed_ch) < NUM_CH)) begin
        ms1[seed_ch] = fix(seed_data[31:0],  32'd2);
        ms2[seed_ch] = fix(seed_data[63:32], 32'd8);
        ms3[seed_ch] = fix(seed_data[95:64], 32'd16);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic seed(input int ch, input logic [95:0] d);
    seed_valid = 1'b1;
    seed_ch    = CH_W'(ch);
    seed_data  = d;
    tick();
    seed_valid = 1'b0;
  endtask

  logic [63:0]      hold_data;
  logic [CNT_W-1:0] hold_cnt;
  logic [31:0]      r1, r2, r3, rs;

  initial begin
    // reset state
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid",   64'(out_valid),  64'd0);
    check("rst_data",    out_data,        64'd0);
    check("rst_running", 64'(running),    64'd0);
    check("rst_cnt",     64'(sample_cnt), 64'd0);
    check("seed_ready",  64'(seed_ready), 64'd1);

    // one channel seeded is not enough to run
    enable = 1'b1; out_ready = 1'b1;
    tick();
    seed(0, 96'd0);
    repeat (5) tick();
    @(negedge clk);
    check("half_running", 64'(running),   64'd0);
    check("half_valid",   64'(out_valid), 64'd0);

    // last seed: RUN right away, first beat one cycle later
    tick();
    seed(1, 96'd0);
    @(negedge clk);
    check("run_now",     64'(running),   64'd1);
    check("first_early", 64'(out_valid), 64'd0);
    tick();
    @(negedge clk);
    check("first_valid", 64'(out_valid), 64'd1);
    check("first_data",  out_data,       64'h00202080_00202080);

    // randomized ready
    for (int i = 0; i < 40; i++) begin
      tick();
      out_ready = ($urandom_range(0, 2) != 0);
    end

    // back-pressure
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    hold_data = out_data;
    hold_cnt  = sample_cnt;
    repeat (10) tick();
    @(negedge clk);
    check("bp_valid", 64'(out_valid),  64'd1);
    check("bp_data",  out_data,        hold_data);
    check("bp_cnt",   64'(sample_cnt), 64'(hold_cnt));
    tick();
    out_ready = 1'b1;
    repeat (20) tick();

    // reseed ch1 mid-stream while delivering
    seed_valid = 1'b1; seed_ch = 1'b1;
    seed_data  = {$urandom, $urandom, $urandom};
    @(negedge clk);
    check("rsd_before", 64'(out_valid), 64'd1);
    tick();
    seed_valid = 1'b0;
    @(negedge clk);
    check("rsd_gap", 64'(out_valid), 64'd0);
    tick();
    @(negedge clk);
    check("rsd_after", 64'(out_valid), 64'd1);
    repeat (5) tick();

    // enable low: beat delivered, nothing generated
    enable = 1'b0;
    tick();
    @(negedge clk);
    check("en_off_valid", 64'(out_valid), 64'd0);
    hold_cnt = sample_cnt;
    repeat (4) tick();
    @(negedge clk);
    check("en_off_cnt",   64'(sample_cnt), 64'(hold_cnt));
    check("en_off_valid2", 64'(out_valid), 64'd0);
    enable = 1'b1;

    // randomized traffic including reseeds and small seeds
    for (int i = 0; i < 400; i++) begin
      tick();
      enable     = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      seed_valid = ($urandom_range(0, 24) == 0);
      seed_ch    = CH_W'($urandom_range(0, NUM_CH - 1));
      if ($urandom_range(0, 2) == 0)
        seed_data = {32'($urandom_range(0, 20)), 32'($urandom_range(0, 10)), 32'($urandom_range(0, 3))};
      else
        seed_data = {$urandom, $urandom, $urandom};
    end
    tick();
    seed_valid = 1'b0; enable = 1'b1; out_ready = 1'b1;
    repeat (3) tick();

    // reset mid-stream, then replay the first run
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst2_valid",   64'(out_valid),  64'd0);
    check("rst2_data",    out_data,        64'd0);
    check("rst2_running", 64'(running),    64'd0);
    check("rst2_cnt",     64'(sample_cnt), 64'd0);
    tick();
    seed(0, 96'd0);
    seed(1, 96'd0);
    tick();
    r1 = 32'd2; r2 = 32'd8; r3 = 32'd16;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      r1 = n1(r1); r2 = n2(r2); r3 = n3(r3);
      rs = r1 ^ r2 ^ r3;
      check("replay", out_data, {rs, rs});
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
